// File: rtl/key_event_pkg.sv
// Shared definitions for the key event generator: state encoding and default hold timings.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_state_e;

  localparam int DEFAULT_LONG_CYCLES   = 8;
  localparam int DEFAULT_REPEAT_CYCLES = 4;

  // Hold counter must represent max(LONG_CYCLES, REPEAT_CYCLES) without wrapping.
  function automatic int hold_cnt_width(input int long_cycles, input int repeat_cycles);
    int largest;
    largest = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/key_event_gen_hold_timer.sv
// Hold counter with clear, enable and terminal-count compare; clear+enable together restarts at one.
module hold_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= enable ? WIDTH'(1) : '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/key_event_gen.sv
// Turns a debounced button level into registered press/release/click/long/repeat events.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int CW = hold_cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

  key_state_e state, next_state;

  logic [CW-1:0] cnt;
  logic [CW-1:0] terminal;
  logic          at_tc;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          press_d, release_d, click_d, long_d, repeat_d;

  hold_timer #(.WIDTH(CW)) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .terminal   (terminal),
    .count      (cnt),
    .at_terminal(at_tc)
  );

  // Outputs are registered alongside the state so every event appears one cycle after its sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= next_state;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      click_pulse   <= click_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= (next_state != IDLE);
      if (press_d) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (level) next_state = PRESSED;
      PRESSED: begin
        if (!level)     next_state = IDLE;
        else if (at_tc) next_state = LONG;
      end
      LONG:    if (!level) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Release is tested first so it always wins over long and repeat on the same sample.
  always_comb begin
    press_d    = 1'b0;
    release_d  = 1'b0;
    click_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    terminal   = (state == LONG) ? REPEAT_TC : LONG_TC;
    case (state)
      IDLE: begin
        if (level) begin
          press_d    = 1'b1;
          cnt_enable = 1'b1;
        end
      end
      PRESSED: begin
        if (!level) begin
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (at_tc) begin
          long_d = 1'b1;
        end else begin
          cnt_clear  = 1'b0;
          cnt_enable = 1'b1;
        end
      end
      LONG: begin
        if (!level) begin
          release_d = 1'b1;
        end else if (repeat_en) begin
          if (at_tc) begin
            repeat_d = 1'b1;
          end else begin
            cnt_clear  = 1'b0;
            cnt_enable = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen against a hold-length based reference model.
module tb_key_event_gen;

  localparam int L = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       level = 1'b0;
  logic       repeat_en = 1'b1;
  logic       press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cyc = 0;

  // Reference model: tracks whether the key is down and how many consecutive highs it has seen.
  bit  m_down;
  int  m_hold;
  int  m_rep;
  int  m_count;
  bit  e_press, e_release, e_click, e_long, e_repeat;

  wire [13:0] act_vec = {press_pulse, release_pulse, click_pulse, long_pulse,
                         repeat_pulse, held, press_count};

  key_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .level        (level),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] exp_vec();
    return {e_press, e_release, e_click, e_long, e_repeat, m_down, 8'(m_count)};
  endfunction

  task automatic model_step(input logic lv, input logic ren, input logic rs);
    {e_press, e_release, e_click, e_long, e_repeat} = '0;
    if (!rs) begin
      m_down = 0; m_hold = 0; m_rep = 0; m_count = 0;
    end else if (!m_down) begin
      if (lv) begin
        m_down = 1; m_hold = 1; m_rep = 0; e_press = 1;
        m_count = (m_count + 1) % 256;
      end
    end else if (!lv) begin
      e_release = 1;
      e_click = (m_hold < L);
      m_down = 0;
    end else begin
      m_hold++;
      if (m_hold == L) e_long = 1;
      else if (m_hold > L) begin
        if (ren) begin
          m_rep++;
          if (m_rep == R) begin e_repeat = 1; m_rep = 0; end
        end else m_rep = 0;
      end
    end
  endtask

  task automatic drive(input logic lv, input logic ren, input logic rs);
    @(negedge clk);
    level = lv; repeat_en = ren; rst_n = rs;
    @(posedge clk);
    model_step(lv, ren, rs);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n_vectors++;
      if (act_vec !== 14'd0) begin
        n_miscompares++;
        $display("[TB] FAIL reset cyc=%0d got=%h want=%h", cyc, act_vec, 14'd0);
      end
    end
  endtask

  task automatic test_short_press();
    int press_cyc, rel_cyc, longs, presses;
    logic [0:7] pat;
    press_cyc = -1; rel_cyc = -1; longs = 0; presses = 0;
    pat = 8'b1110_0000;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(pat[i], 1'b1, 1'b1);
      n_vectors++;
      if (act_vec !== exp_vec()) begin
        n_miscompares++;
        $display("[TB] FAIL short_press cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
      if (press_pulse) begin presses++; press_cyc = i; end
      if (long_pulse) longs++;
      if (release_pulse && click_pulse) rel_cyc = i;
    end
    n_vectors++;
    if (presses != 1 || longs != 0 || rel_cyc - press_cyc != 3 || press_count !== 8'd1) begin
      n_miscompares++;
      $display("[TB] FAIL short_summary got presses=%0d longs=%0d gap=%0d count=%0d want 1 0 3 1",
               presses, longs, rel_cyc - press_cyc, press_count);
    end
  endtask

  task automatic test_long_hold(input logic ren);
    int press_cyc, long_cyc, reps, held_low, clicks;
    int rep_cyc[$];
    press_cyc = -1; long_cyc = -1; reps = 0; held_low = 0; clicks = 0;
    drive(1'b0, ren, 1'b0);
    for (int i = 0; i < 23; i++) begin
      drive(i < 20, ren, 1'b1);
      n_vectors++;
      if (act_vec !== exp_vec()) begin
        n_miscompares++;
        $display("[TB] FAIL long_hold ren=%0b cyc=%0d got=%h want=%h", ren, cyc, act_vec, exp_vec());
      end
      if (press_pulse) press_cyc = i;
      if (long_pulse) long_cyc = i;
      if (repeat_pulse) begin reps++; rep_cyc.push_back(i - press_cyc); end
      if (i < 20 && !held) held_low++;
      if (click_pulse) clicks++;
    end
    // Press is high sample 1; long lands on sample 8, repeats on samples 12, 16, 20.
    n_vectors++;
    if (long_cyc - press_cyc != 7 || clicks != 0 || held_low != 0 || reps != (ren ? 3 : 0)) begin
      n_miscompares++;
      $display("[TB] FAIL long_summary ren=%0b got long_off=%0d clicks=%0d held_low=%0d reps=%0d",
               ren, long_cyc - press_cyc, clicks, held_low, reps);
    end
    if (ren && reps == 3) begin
      n_vectors++;
      if (rep_cyc[0] != 11 || rep_cyc[1] != 15 || rep_cyc[2] != 19) begin
        n_miscompares++;
        $display("[TB] FAIL repeat_offsets got=%0d,%0d,%0d want=11,15,19",
                 rep_cyc[0], rep_cyc[1], rep_cyc[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:6] pat;
    pat = 7'b1101100;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(pat[i], 1'b1, 1'b1);
      n_vectors++;
      if (act_vec !== exp_vec()) begin
        n_miscompares++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
      if (i == 3 && !(press_pulse && !release_pulse)) begin
        n_miscompares++;
        $display("[TB] FAIL second_press got press=%0b want 1", press_pulse);
      end
    end
    n_vectors++;
    if (press_count !== 8'd2) begin
      n_miscompares++;
      $display("[TB] FAIL b2b_count got=%0d want=2", press_count);
    end
  endtask

  task automatic test_reset_mid_long();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    n_vectors++;
    if (act_vec !== 14'd0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_mid_long got=%h want=%h", act_vec, 14'd0);
    end
    drive(1'b1, 1'b1, 1'b1);
    n_vectors++;
    if (press_pulse !== 1'b1 || press_count !== 8'd1 || act_vec !== exp_vec()) begin
      n_miscompares++;
      $display("[TB] FAIL fresh_press got press=%0b count=%0d want 1 1", press_pulse, press_count);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      n_vectors++;
      if (act_vec !== exp_vec()) begin
        n_miscompares++;
        $display("[TB] FAIL wrap_press n=%0d got=%h want=%h", i, act_vec, exp_vec());
      end
      drive(1'b0, 1'b1, 1'b1);
    end
    n_vectors++;
    if (press_count !== 8'd0) begin
      n_miscompares++;
      $display("[TB] FAIL wrap_count got=%0d want=0", press_count);
    end
  endtask

  task automatic test_random();
    int seg_len;
    logic lv, ren, rs;
    drive(1'b0, 1'b1, 1'b0);
    lv = 1'b0;
    for (int s = 0; s < 150; s++) begin
      lv = ~lv;
      seg_len = (s % 5 == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 25));
      for (int k = 0; k < seg_len; k++) begin
        ren = ($urandom_range(0, 9) != 0);
        rs = ($urandom_range(0, 99) != 0);
        drive(lv, ren, rs);
        n_vectors++;
        if (act_vec !== exp_vec()) begin
          n_miscompares++;
          $display("[TB] FAIL random cyc=%0d lv=%0b ren=%0b rs=%0b got=%h want=%h",
                   cyc, lv, ren, rs, act_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold(1'b1);
    test_long_hold(1'b0);
    test_back_to_back();
    test_reset_mid_long();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
